// File: rtl/cpu_sequencer.sv
// cpu_sequencer
// Multi-cycle instruction sequencer for the 9-bit-opcode core. Steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB, owns the program counter,
// runs the data-memory request/ready handshake, gates register-file and
// memory writes from the latched decoder controls, and stops on HALT.
// It also keeps saturating cycle and retired-instruction counters.
//
// Ports:
//   CLK, RESET_N        clock (rising edge) / asynchronous active-low reset
//   START               start/restart pulse, honoured in IDLE or HALTED only
//   DEC_*               decoder control flags, sampled in DECODE
//   BR_TAKEN, BR_TARGET branch condition and absolute target, sampled in EXEC
//   DMEM_READY          data memory completion, sampled in MEM only
//   PC                  current instruction address
//   IR_LOAD             one-cycle pulse in FETCH
//   DMEM_REQ, DMEM_WE   data memory request (held through MEM) and write qualifier
//   REG_WE              one-cycle register-file write enable in WB
//   DONE                high while HALTED
//   CYCLE_COUNT         cycles spent in active states
//   INSTR_COUNT         retired instructions
// All outputs are decoded from registered state only.
module cpu_sequencer #(
  parameter int PC_WIDTH  = 10,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 START,
  input  logic                 DEC_REG_WRITE,
  input  logic                 DEC_MEM_READ,
  input  logic                 DEC_MEM_WRITE,
  input  logic                 DEC_BRANCH,
  input  logic                 DEC_HALT,
  input  logic                 BR_TAKEN,
  input  logic [PC_WIDTH-1:0]  BR_TARGET,
  input  logic                 DMEM_READY,
  output logic [PC_WIDTH-1:0]  PC,
  output logic                 IR_LOAD,
  output logic                 DMEM_REQ,
  output logic                 DMEM_WE,
  output logic                 REG_WE,
  output logic                 DONE,
  output logic [CNT_WIDTH-1:0] CYCLE_COUNT,
  output logic [CNT_WIDTH-1:0] INSTR_COUNT
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALTED = 3'd6
  } state_t;

  localparam logic [PC_WIDTH-1:0]  PC_ZERO  = {PC_WIDTH{1'b0}};
  localparam logic [PC_WIDTH-1:0]  PC_ONE   = {{(PC_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  state_t               state_r;
  state_t               state_s;
  logic [PC_WIDTH-1:0]  pc_r;
  logic [PC_WIDTH-1:0]  target_r;
  logic [CNT_WIDTH-1:0] cycle_cnt_r;
  logic [CNT_WIDTH-1:0] instr_cnt_r;
  logic                 reg_write_r;
  logic                 mem_read_r;
  logic                 mem_write_r;
  logic                 branch_r;
  logic                 taken_r;
  logic                 active_s;

  // Saturating increment shared by both counters.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_ONE;
    end
  endfunction

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_s  = state_r;
    IR_LOAD  = 1'b0;
    DMEM_REQ = 1'b0;
    DMEM_WE  = 1'b0;
    REG_WE   = 1'b0;
    DONE     = 1'b0;
    active_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (START) state_s = S_FETCH;
        else       state_s = S_IDLE;
      end
      S_FETCH: begin
        IR_LOAD  = 1'b1;
        active_s = 1'b1;
        state_s  = S_DECODE;
      end
      S_DECODE: begin
        active_s = 1'b1;
        if (DEC_HALT) state_s = S_HALTED;
        else          state_s = S_EXEC;
      end
      S_EXEC: begin
        active_s = 1'b1;
        if (mem_read_r || mem_write_r) state_s = S_MEM;
        else                           state_s = S_WB;
      end
      S_MEM: begin
        active_s = 1'b1;
        DMEM_REQ = 1'b1;
        // A latched write takes priority over a latched read.
        DMEM_WE  = mem_write_r;
        if (DMEM_READY) state_s = S_WB;
        else            state_s = S_MEM;
      end
      S_WB: begin
        active_s = 1'b1;
        REG_WE   = reg_write_r;
        state_s  = S_FETCH;
      end
      S_HALTED: begin
        DONE = 1'b1;
        if (START) state_s = S_FETCH;
        else       state_s = S_HALTED;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // PC, latched decoder controls, branch resolution and counters.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pc_r        <= PC_ZERO;
      target_r    <= PC_ZERO;
      cycle_cnt_r <= CNT_ZERO;
      instr_cnt_r <= CNT_ZERO;
      reg_write_r <= 1'b0;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
      branch_r    <= 1'b0;
      taken_r     <= 1'b0;
    end else begin
      if (active_s) begin
        cycle_cnt_r <= sat_inc(cycle_cnt_r);
      end
      case (state_r)
        S_IDLE, S_HALTED: begin
          // Restart clears PC and counters; the active-state increment
          // above cannot fire in these states, so there is no conflict.
          if (START) begin
            pc_r        <= PC_ZERO;
            cycle_cnt_r <= CNT_ZERO;
            instr_cnt_r <= CNT_ZERO;
          end
        end
        S_DECODE: begin
          // A HALT leaves the flags alone so nothing can be written.
          if (!DEC_HALT) begin
            reg_write_r <= DEC_REG_WRITE;
            mem_read_r  <= DEC_MEM_READ;
            mem_write_r <= DEC_MEM_WRITE;
            branch_r    <= DEC_BRANCH;
          end
        end
        S_EXEC: begin
          taken_r  <= branch_r & BR_TAKEN;
          target_r <= BR_TARGET;
        end
        S_WB: begin
          // PC + 1 wraps naturally at PC_WIDTH bits.
          if (taken_r) pc_r <= target_r;
          else         pc_r <= pc_r + PC_ONE;
          instr_cnt_r <= sat_inc(instr_cnt_r);
        end
        default: begin
        end
      endcase
    end
  end

  assign PC          = pc_r;
  assign CYCLE_COUNT = cycle_cnt_r;
  assign INSTR_COUNT = instr_cnt_r;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;
  localparam int PW = 10;
  localparam int CW = 16;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic          START;
  logic          DEC_REG_WRITE, DEC_MEM_READ, DEC_MEM_WRITE, DEC_BRANCH, DEC_HALT;
  logic          BR_TAKEN;
  logic [PW-1:0] BR_TARGET;
  logic          DMEM_READY;
  logic [PW-1:0] PC;
  logic          IR_LOAD, DMEM_REQ, DMEM_WE, REG_WE, DONE;
  logic [CW-1:0] CYCLE_COUNT, INSTR_COUNT;

  always #5 CLK = ~CLK;

  cpu_sequencer #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START),
    .DEC_REG_WRITE(DEC_REG_WRITE), .DEC_MEM_READ(DEC_MEM_READ),
    .DEC_MEM_WRITE(DEC_MEM_WRITE), .DEC_BRANCH(DEC_BRANCH), .DEC_HALT(DEC_HALT),
    .BR_TAKEN(BR_TAKEN), .BR_TARGET(BR_TARGET), .DMEM_READY(DMEM_READY),
    .PC(PC), .IR_LOAD(IR_LOAD), .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE),
    .REG_WE(REG_WE), .DONE(DONE), .CYCLE_COUNT(CYCLE_COUNT), .INSTR_COUNT(INSTR_COUNT)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One instruction per record: decoder/ALU inputs, memory wait cycles,
  // an optional START pulse during EXEC, and the expected results.
  typedef struct {
    logic          rw, mr, mw, br, tk;
    logic [PW-1:0] tgt;
    int            dly;
    bit            mid_start;
    logic [PW-1:0] exp_pc;
    int            exp_cyc, exp_rwe, exp_req, exp_we;
  } vec_t;

  vec_t tbl[12];

  task automatic clear_dec();
    DEC_REG_WRITE = 1'b0; DEC_MEM_READ = 1'b0; DEC_MEM_WRITE = 1'b0;
    DEC_BRANCH = 1'b0; DEC_HALT = 1'b0; BR_TAKEN = 1'b0; BR_TARGET = '0;
  endtask

  initial begin
    logic [15:0] ir_mask, we_mask;
    int fidx, done_at, cyc_sum;
    logic [PW-1:0] pc_at_done;
    logic [CW-1:0] ic_at_done, cc_at_done;
    bit found;

    //            rw   mr   mw   br   tk   tgt      dly st  exp_pc   cyc rwe req we
    tbl[0]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,10'd5,    0, 1'b0,10'd5,    4, 0, 0, 0}; // jump to 5
    tbl[1]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,10'd0,    2, 1'b0,10'd6,    7, 1, 3, 0}; // lw, 2 waits
    tbl[2]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,10'd0,    0, 1'b0,10'd7,    5, 0, 1, 1}; // sw, ready high
    tbl[3]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,10'd2,    0, 1'b0,10'd8,    4, 0, 0, 0}; // branch not taken
    tbl[4]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,10'd7,    0, 1'b0,10'd7,    4, 0, 0, 0}; // back to 7
    tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,10'd2,    0, 1'b0,10'd8,    4, 0, 0, 0}; // taken w/o BRANCH
    tbl[6]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,10'd7,    0, 1'b0,10'd7,    4, 0, 0, 0}; // back to 7
    tbl[7]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,10'd2,    0, 1'b0,10'd2,    4, 0, 0, 0}; // branch taken
    tbl[8]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,10'd1023, 0, 1'b0,10'd1023, 4, 0, 0, 0}; // to top
    tbl[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,10'd5,    0, 1'b1,10'd0,    4, 1, 0, 0}; // wrap + START
    tbl[10] = '{1'b0,1'b1,1'b1,1'b0,1'b0,10'd0,    1, 1'b0,10'd1,    6, 0, 2, 2}; // rd+wr: write wins
    tbl[11] = '{1'b1,1'b1,1'b0,1'b0,1'b0,10'd0,    0, 1'b0,10'd2,    5, 1, 1, 0}; // lw, no wait

    RESET_N = 1'b0; START = 1'b0; DMEM_READY = 1'b0;
    clear_dec();
    repeat (3) @(negedge CLK);
    check("rst_pc", PC, 0);
    check("rst_outs", {IR_LOAD, DMEM_REQ, DMEM_WE, REG_WE, DONE}, 0);
    check("rst_cnts", {CYCLE_COUNT, INSTR_COUNT}, 0);
    RESET_N = 1'b1;
    repeat (3) @(negedge CLK);
    check("idle_no_fetch", IR_LOAD, 0);
    check("idle_cycles", CYCLE_COUNT, 0);

    // Three adds then HALT, cycle by cycle.
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    ir_mask = '0; we_mask = '0; fidx = 0; done_at = -1;
    pc_at_done = '0; ic_at_done = '0; cc_at_done = '0;
    for (int c = 0; c < 16; c++) begin
      if (IR_LOAD) begin
        DEC_REG_WRITE = (fidx < 3);
        DEC_HALT      = (fidx == 3);
        if (fidx < 4) check($sformatf("seq_pc_fetch%0d", fidx), PC, fidx);
        fidx++;
      end
      ir_mask[c] = IR_LOAD;
      we_mask[c] = REG_WE;
      if (DONE && done_at < 0) begin
        done_at = c; pc_at_done = PC; ic_at_done = INSTR_COUNT; cc_at_done = CYCLE_COUNT;
      end
      @(negedge CLK);
    end
    check("seq_ir_load_mask", ir_mask, 32'h1111);
    check("seq_reg_we_mask", we_mask, 32'h0888);
    check("seq_done_cycle", done_at, 14);
    check("seq_done_pc", pc_at_done, 3);
    check("seq_instr_count", ic_at_done, 3);
    check("seq_cycle_count", cc_at_done, 14);
    check("seq_done_held", DONE, 1);
    clear_dec();

    // Restart from HALTED and run the table.
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    check("restart_fetch", IR_LOAD, 1);
    check("restart_pc", PC, 0);
    check("restart_cnts", {CYCLE_COUNT, INSTR_COUNT}, 0);
    cyc_sum = 0;
    for (int i = 0; i < 12; i++) begin
      int n, rwe, req, we, seen;
      DEC_REG_WRITE = tbl[i].rw; DEC_MEM_READ = tbl[i].mr; DEC_MEM_WRITE = tbl[i].mw;
      DEC_BRANCH = tbl[i].br; DEC_HALT = 1'b0; BR_TAKEN = tbl[i].tk; BR_TARGET = tbl[i].tgt;
      n = 0; rwe = 0; req = 0; we = 0; seen = 0;
      do begin
        START = (tbl[i].mid_start && n == 2);
        if (REG_WE) rwe++;
        if (DMEM_WE) we++;
        if (DMEM_REQ) begin
          req++;
          DMEM_READY = (seen >= tbl[i].dly);
          seen++;
        end else begin
          DMEM_READY = 1'b1;
        end
        n++;
        @(negedge CLK);
      end while (!IR_LOAD && n < 50);
      START = 1'b0;
      cyc_sum += tbl[i].exp_cyc;
      check($sformatf("v%0d_pc", i), PC, tbl[i].exp_pc);
      check($sformatf("v%0d_cycles", i), n, tbl[i].exp_cyc);
      check($sformatf("v%0d_reg_we", i), rwe, tbl[i].exp_rwe);
      check($sformatf("v%0d_dmem_req", i), req, tbl[i].exp_req);
      check($sformatf("v%0d_dmem_we", i), we, tbl[i].exp_we);
      check($sformatf("v%0d_instr_count", i), INSTR_COUNT, i + 1);
      check($sformatf("v%0d_cycle_count", i), CYCLE_COUNT, cyc_sum);
    end

    // Asynchronous reset while waiting in MEM.
    DEC_REG_WRITE = 1'b1; DEC_MEM_READ = 1'b1; DEC_MEM_WRITE = 1'b0;
    DEC_BRANCH = 1'b0; BR_TAKEN = 1'b0; DMEM_READY = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge CLK);
      if (DMEM_REQ) found = 1'b1;
    end
    check("rstmem_reached_mem", found, 1);
    #2 RESET_N = 1'b0;
    #1;
    check("rstmem_req", DMEM_REQ, 0);
    check("rstmem_pc", PC, 0);
    check("rstmem_cnts", {CYCLE_COUNT, INSTR_COUNT}, 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    DMEM_READY = 1'b1;
    repeat (5) @(negedge CLK);
    check("rstmem_idle_outs", {IR_LOAD, DMEM_REQ, REG_WE, DONE}, 0);
    check("rstmem_idle_cycles", CYCLE_COUNT, 0);
    check("rstmem_idle_pc", PC, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
